// File: rtl/display_status_scan.sv
// Multiplexed 7-segment status display for N_CH water-entry channels.
// Each digit shows one channel: a live error, a latched (blinking) error,
// an open inlet valve, or idle. Asynchronous inputs are double-synchronised,
// digits are scanned by a prescaled tick, and error latches clear on ack.
module display_status_scan #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] erro,
  input  logic [N_CH-1:0] ve,
  input  logic            ack,
  output logic [6:0]      seg,
  output logic            seg_p,
  output logic [N_CH-1:0] an
);

  // Counter widths: $clog2 of the modulus, never narrower than one bit.
  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, logical polarity.
  localparam logic [6:0] SegE     = 7'b1111001;
  localparam logic [6:0] SegOne   = 7'b0000110;
  localparam logic [6:0] SegUnder = 7'b0001000;
  localparam logic [6:0] SegBlank = 7'b0000000;

  // Physical "off" levels; the output registers hold pin polarity directly.
  localparam logic            Inv      = ACTIVE_LOW;
  localparam logic [6:0]      SegOff   = {7{Inv}};
  localparam logic [N_CH-1:0] AnOff    = {N_CH{Inv}};

  logic [N_CH-1:0]   erro_q1, erro_s;
  logic [N_CH-1:0]   ve_q1, ve_s;
  logic [N_CH-1:0]   err_lat_q, err_lat_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic              tick;

  logic [6:0]        glyph;
  logic              glyph_dp;
  logic [N_CH-1:0]   an_log;

  logic [6:0]        seg_q;
  logic              seg_p_q;
  logic [N_CH-1:0]   an_q;

  // Two-flop synchronisers for the asynchronous error and valve flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erro_q1 <= '0;
      erro_s  <= '0;
      ve_q1   <= '0;
      ve_s    <= '0;
    end else begin
      erro_q1 <= erro;
      erro_s  <= erro_q1;
      ve_q1   <= ve;
      ve_s    <= ve_q1;
    end
  end

  assign tick = (presc_q == PrescW'(SCAN_DIV - 1));

  // Next-state for prescaler, digit index and blink phase.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (tick) begin
      idx_d = (idx_q == IdxW'(N_CH - 1)) ? '0 : idx_q + 1'b1;
      if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Scan timing state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // A live error always sets its latch; ack clears only quiet channels.
  always_comb begin
    err_lat_d = ack ? erro_s : (err_lat_q | erro_s);
  end

  // Sticky per-channel error latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_lat_q <= '0;
    end else begin
      err_lat_q <= err_lat_d;
    end
  end

  // Glyph selection for the currently scanned channel, highest priority first.
  always_comb begin
    glyph    = SegUnder;
    glyph_dp = 1'b0;
    if (erro_s[idx_q]) begin
      glyph = SegE;
    end else if (err_lat_q[idx_q]) begin
      glyph    = blink_on_q ? SegE : SegBlank;
      glyph_dp = 1'b1;
    end else if (ve_s[idx_q]) begin
      glyph = SegOne;
    end
  end

  // Digit enable: blanked for the first cycle of every slot to avoid ghosting.
  always_comb begin
    an_log = (presc_q == '0) ? '0 : (N_CH'(1) << idx_q);
  end

  // Registered pin drivers, polarity applied here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= SegOff;
      seg_p_q <= Inv;
      an_q    <= AnOff;
    end else begin
      seg_q   <= glyph ^ SegOff;
      seg_p_q <= glyph_dp ^ Inv;
      an_q    <= an_log ^ AnOff;
    end
  end

  assign seg   = seg_q;
  assign seg_p = seg_p_q;
  assign an    = an_q;

endmodule
